acc_len_ctrl: RTL
=================

Name: acc_len_ctrl

Overview:
- Accumulation sequencer for the correlator's vector accumulators, in the user_clk (DSP) domain.
- Consumes the software-written accumulation length (acc_length register output, 32 b) and an arm bit, aligns to the FFT frame sync, and drives the enable, first and last strobes into the accumulator datapath.
- Emits a one-cycle dump strobe per completed integration so downstream capture/readout logic can latch results, and keeps a completed-integration counter for software.

Parameters:
VEC_LEN, 1024, clocks per spectrum vector (samples per sync period); must be ≥ 2
VEC_W, 10, width of sample counter; ceil(log2(VEC_LEN))
CNT_W, 32, width of acc_length, vector counter and acc_cnt

Ports:
user_clk  in  1  DSP clock; all logic on rising edge
user_rst_n  in  1  asynchronous active-low reset
acc_length  in  CNT_W  number of vectors per integration (from register); latched at arm
arm  in  1  level from software register; rising edge starts, level high = continuous mode
sync_in  in  1  one-cycle FFT frame sync pulse; first sample of vector is the cycle after
acc_en  out  1  high on every cycle whose sample is to be accumulated
acc_first  out  1  high with acc_en during vector 0 (datapath loads instead of adds)
acc_last  out  1  high with acc_en during vector len_q-1
acc_dump  out  1  one-cycle pulse after last sample of an integration
acc_cnt  out  CNT_W  completed integrations, wraps at 2^CNT_W
busy  out  1  high in WAIT_SYNC, ACCUM, DUMP
len_err  out  1  sticky: arm attempted with acc_length == 0

Behaviour:
- Reset (async, user_rst_n low): state IDLE; all outputs 0; acc_cnt 0; len_q, sample_cnt, vec_cnt 0; arm edge register 0. Takes effect immediately, mid-integration included; no dump is produced for an aborted integration.
- All outputs registered; no combinational input-to-output paths.
- arm_rise = arm & ~arm_d (arm_d registered).
- States:
  - IDLE: on arm_rise, if acc_length == 0, set len_err and stay IDLE. Otherwise latch len_q = acc_length, clear len_err, go to WAIT_SYNC.
  - WAIT_SYNC: on sync_in, go to ACCUM with sample_cnt = 0 and vec_cnt = 0. acc_en rises on the cycle after sync_in (sync at cycle t gives first acc_en at t+1).
  - ACCUM: acc_en = 1 every cycle. sample_cnt increments and wraps at VEC_LEN-1; on wrap, vec_cnt increments. acc_first = (vec_cnt == 0); acc_last = (vec_cnt == len_q-1). On sample_cnt == VEC_LEN-1 with vec_cnt == len_q-1, go to DUMP.
  - DUMP (1 cycle): acc_en/first/last = 0; acc_dump = 1; acc_cnt += 1. Then:
    - if arm is high, relatch len_q = acc_length and go to WAIT_SYNC (if acc_length == 0: set len_err, go to IDLE);
    - otherwise go to IDLE.
- Timing: with a sync at cycle t, acc_dump asserts at cycle t+1+len_q*VEC_LEN.
- sync_in in ACCUM or DUMP is ignored; no resync mid-integration. Continuous mode therefore needs a fresh sync after each DUMP; the datapath loses at least one vector between integrations.
- arm falling during ACCUM: the current integration completes normally, including its dump, then goes to IDLE. An arm re-rise before DUMP is a no-op.
- acc_length changes outside IDLE/DUMP relatch have no effect.
- len_q == 1: acc_first and acc_last are both high for the whole vector.
- acc_cnt wraps from 2^CNT_W-1 to 0 without a flag.
- sync_in on the same cycle as arm_rise in IDLE is not honoured; the next sync is used.

Test Plan (VEC_LEN=8):
1. Reset, acc_length=2, arm 0→1 held one cycle then 0, sync at cycle 10 → acc_en high cycles 11–26; acc_first high 11–18; acc_last high 19–26; acc_dump at 27; acc_cnt=1; busy 0 from 28.
2. acc_length=0, arm rise → len_err=1, busy stays 0. Then acc_length=3, arm rise → len_err=0, busy=1.
3. Continuous mode: arm held high, acc_length=1, syncs every 12 cycles → acc_first and acc_last both high for 8 cycles per integration, one dump per integration; acc_cnt increments 1,2,3. Extra syncs during ACCUM produce no change.
4. Mid-integration change: acc_length changed 2→5 during ACCUM with arm high → first integration still 16 acc_en cycles; next integration 40 cycles.
5. Assert user_rst_n low during ACCUM at vec_cnt=1 → all outputs 0 asynchronously; no acc_dump; acc_cnt=0 after release.
6. arm drops mid-ACCUM (acc_length=4) → integration completes, acc_dump once, then IDLE; later syncs produce no acc_en.

Source files
------------

// File: rtl/acc_len_ctrl_if.sv
// Control/status bundle between the accumulation sequencer and its
// software register block / accumulator datapath.
interface acc_len_ctrl_if #(
  parameter int CNT_W = 32
);
  // arm is a level (rising edge starts, held high = continuous); sync_in and
  // acc_dump are single-cycle pulses; acc_en/first/last are per-sample
  // qualifiers. There is no back-pressure: the receiver must accept every pulse.
  logic [CNT_W-1:0] acc_length;
  logic             arm;
  logic             sync_in;
  logic             acc_en;
  logic             acc_first;
  logic             acc_last;
  logic             acc_dump;
  logic [CNT_W-1:0] acc_cnt;
  logic             busy;
  logic             len_err;
  logic [1:0]       state_dbg;

  modport master (
    output acc_length, arm, sync_in,
    input  acc_en, acc_first, acc_last, acc_dump, acc_cnt, busy, len_err, state_dbg
  );

  modport slave (
    input  acc_length, arm, sync_in,
    output acc_en, acc_first, acc_last, acc_dump, acc_cnt, busy, len_err, state_dbg
  );
endinterface

// File: rtl/acc_len_ctrl.sv
// Accumulation sequencer: aligns an armed integration of len_q vectors to the
// FFT frame sync and drives the accumulator enable/first/last/dump strobes.
module acc_len_ctrl #(
  parameter int VEC_LEN = 1024,
  parameter int VEC_W   = 10,
  parameter int CNT_W   = 32
) (
  input  logic          user_clk,
  input  logic          user_rst_n,
  acc_len_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    ACCUM     = 2'd2,
    DUMP      = 2'd3
  } state_t;

  localparam logic [VEC_W-1:0] SAMPLE_LAST = VEC_W'(VEC_LEN - 1);

  state_t           state_q, state_n;
  logic             arm_d;
  logic             arm_rise;
  logic [CNT_W-1:0] len_q, len_n;
  logic [CNT_W-1:0] len_m1;
  logic [VEC_W-1:0] sample_q, sample_n;
  logic [CNT_W-1:0] vec_q, vec_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             err_q, err_n;
  logic             en_q, en_n;
  logic             first_q, first_n;
  logic             last_q, last_n;
  logic             dump_q, dump_n;
  logic             busy_q, busy_n;

  assign arm_rise = bus.arm & ~arm_d;
  assign len_m1   = len_q - CNT_W'(1);

  // Outputs are computed for the state being entered and registered, so the
  // strobes describe the sample present on the cycle they are visible.
  always_comb begin
    state_n  = state_q;
    len_n    = len_q;
    sample_n = sample_q;
    vec_n    = vec_q;
    cnt_n    = cnt_q;
    err_n    = err_q;
    en_n     = 1'b0;
    first_n  = 1'b0;
    last_n   = 1'b0;
    dump_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_rise) begin
          if (bus.acc_length == '0) begin
            err_n = 1'b1;
          end else begin
            len_n   = bus.acc_length;
            err_n   = 1'b0;
            state_n = WAIT_SYNC;
          end
        end
      end
      WAIT_SYNC: begin
        if (bus.sync_in) begin
          state_n  = ACCUM;
          sample_n = '0;
          vec_n    = '0;
          en_n     = 1'b1;
          first_n  = 1'b1;
          last_n   = (len_m1 == '0);
        end
      end
      ACCUM: begin
        if (sample_q == SAMPLE_LAST) begin
          if (vec_q == len_m1) begin
            state_n = DUMP;
            dump_n  = 1'b1;
            cnt_n   = cnt_q + CNT_W'(1);
          end else begin
            sample_n = '0;
            vec_n    = vec_q + CNT_W'(1);
            en_n     = 1'b1;
            last_n   = (vec_q + CNT_W'(1) == len_m1);
          end
        end else begin
          sample_n = sample_q + VEC_W'(1);
          en_n     = 1'b1;
          first_n  = (vec_q == '0);
          last_n   = (vec_q == len_m1);
        end
      end
      DUMP: begin
        state_n = IDLE;
        if (bus.arm) begin
          if (bus.acc_length == '0) begin
            err_n = 1'b1;
          end else begin
            len_n   = bus.acc_length;
            err_n   = 1'b0;
            state_n = WAIT_SYNC;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q  <= IDLE;
      arm_d    <= 1'b0;
      len_q    <= '0;
      sample_q <= '0;
      vec_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      dump_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      arm_d    <= bus.arm;
      len_q    <= len_n;
      sample_q <= sample_n;
      vec_q    <= vec_n;
      cnt_q    <= cnt_n;
      err_q    <= err_n;
      en_q     <= en_n;
      first_q  <= first_n;
      last_q   <= last_n;
      dump_q   <= dump_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.acc_en    = en_q;
  assign bus.acc_first = first_q;
  assign bus.acc_last  = last_q;
  assign bus.acc_dump  = dump_q;
  assign bus.acc_cnt   = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.len_err   = err_q;
  assign bus.state_dbg = state_q;

endmodule
